// File: rtl/serial_subtractor8_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor8_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor8_full_subtractor1.sv
// One-bit full subtractor: d = a - b - bi, borrow out on bo.
// Purely combinational; reused once per cycle by the serial engine.
module full_subtractor1 (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: d = a - b - bi, one bit per cycle, LSB first.
// Result and borrow-out are held from the done pulse until the next start.
module serial_subtractor8
    import serial_subtractor8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             fs_d;
    logic             fs_bo;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    full_subtractor1 u_fs (
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .bi (brw),
        .d  (fs_d),
        .bo (fs_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands are latched so input changes mid-operation are harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            brw <= 1'b0;
            d   <= '0;
            bo  <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            a_q <= a;
            b_q <= b;
            cnt <= '0;
            brw <= bi;
        end else if (state == ST_BUSY) begin
            d[cnt] <= fs_d;
            brw    <= fs_bo;
            if (last_bit) begin
                bo <= fs_bo;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed bench for serial_subtractor8: latency, results, hold,
// back-to-back starts, ignored starts and asynchronous reset abort.
module tb_serial_subtractor8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bo;

    int n_chk;
    int n_err;

    serial_subtractor8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ref_sub(input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic c);
        logic [8:0] r;
        r = {1'b0, x} - {1'b0, y} - {8'd0, c};
        return r;
    endfunction

    // Launch one operation and wait (bounded) for done; returns edge count
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tbi, output int lat);
        @(negedge clk);
        a = ta; b = tb_; bi = tbi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic op_check(input string tag, input logic [7:0] ta,
                            input logic [7:0] tb_, input logic tbi);
        int lat;
        logic [8:0] r;
        r = ref_sub(ta, tb_, tbi);
        do_op(ta, tb_, tbi, lat);
        chk({tag, " lat"}, lat, 8);
        chk({tag, " d"}, d, r[7:0]);
        chk({tag, " bo"}, bo, r[8]);
        @(posedge clk);
        #1;
        chk({tag, " done1"}, done, 0);
    endtask

    logic [7:0] corners [9];
    int lat;
    int ndone;
    int pos1;
    int pos2;
    int saw_done;

    initial begin
        corners = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254,
                    8'd255, 8'h55, 8'hAA};
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; bi = 1'b0;
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst d", d, 0);
        chk("rst bo", bo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First start right after release, with latency check
        do_op(8'd26, 8'd15, 1'b1, lat);
        chk("v1 lat", lat, 8);
        chk("v1 d", d, 10);
        chk("v1 bo", bo, 0);
        chk("v1 busy", busy, 1);
        @(posedge clk);
        #1;
        chk("v1 idle", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("v1 hold d", d, 10);
        chk("v1 hold bo", bo, 0);

        op_check("v2", 8'd0, 8'd1, 1'b0);
        chk("v2 d255", d, 255);
        op_check("v3", 8'd255, 8'd255, 1'b1);
        chk("v3 bo1", bo, 1);

        // start held high: second operation accepted 10 edges later
        @(negedge clk);
        a = 8'd173; b = 8'd49; bi = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0; pos1 = -1; pos2 = -1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (pos1 < 0) begin
                    pos1 = k;
                    chk("b2b d", d, 123);
                    chk("b2b bo", bo, 0);
                end else begin
                    pos2 = k;
                end
            end
            if (k == 9) chk("b2b idle9", busy, 0);
            if (k == 10) begin
                chk("b2b busy10", busy, 1);
                start = 1'b0;
            end
        end
        chk("b2b ndone", ndone, 2);
        chk("b2b pos1", pos1, 8);
        chk("b2b pos2", pos2, 18);
        chk("b2b d2", d, 123);
        @(posedge clk);
        #1;
        chk("b2b end", busy, 0);

        // start re-pulsed with new operands mid-operation is ignored
        @(negedge clk);
        a = 8'd200; b = 8'd100; bi = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1; ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                start = 1'b1; a = 8'd0; b = 8'd0;
            end
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k >= 12) break;
        end
        chk("ign lat", lat, 8);
        chk("ign ndone", ndone, 1);
        chk("ign d", d, 100);
        chk("ign bo", bo, 0);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        a = 8'd200; b = 8'd55; bi = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar busy", busy, 0);
        chk("ar done", done, 0);
        chk("ar d", d, 0);
        chk("ar bo", bo, 0);
        saw_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        chk("ar nodone", saw_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op_check("ar post", 8'd200, 8'd55, 1'b0);

        // Corner sweep and random sample against the reference model
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                for (int c = 0; c < 2; c++) begin
                    op_check("corner", corners[i], corners[j], c[0]);
                end
            end
        end
        for (int n = 0; n < 400; n++) begin
            op_check("rand", 8'($urandom), 8'($urandom),
                     1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor8.md
SERIAL_SUBTRACTOR8 -- requirements
Module: serial_subtractor8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8: operand and difference width in bits.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request; sampled only while idle.
REQ-006 Port a  input  WIDTH  minuend, captured on accepted start.
REQ-007 Port b  input  WIDTH  subtrahend, captured on accepted start.
REQ-008 Port bi  input  1  borrow-in, captured on accepted start.
REQ-009 Port busy  output  1  high while an operation is in progress.
REQ-010 Port done  output  1  single-cycle pulse: result valid.
REQ-011 Port d  output  WIDTH  difference a - b - bi, modulo 2^WIDTH.
REQ-012 Port bo  output  1  borrow-out; 1 when a < b + bi (unsigned).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL capture a, b and bi, clear the bit counter, load the borrow register with bi and enter BUSY.
REQ-015 IDLE with start=0 SHALL remain in IDLE.
REQ-016 BUSY SHALL process one bit per edge, LSB first: bit i at edge E(i+1), for i = 0..WIDTH-1.
REQ-017 Per bit: d[i] = a[i] ^ b[i] ^ brw; brw_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw).
REQ-018 At edge E(WIDTH), after bit WIDTH-1, bo SHALL take the final borrow and the FSM SHALL enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; the total is WIDTH+1 edges from start to the return to IDLE.
REQ-020 busy SHALL be 1 in BUSY and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored in BUSY and DONE; a, b and bi changing during BUSY SHALL NOT affect the result.
REQ-022 d and bo SHALL hold the last result from the DONE cycle until the next start is accepted.
REQ-023 d and bo SHALL be undefined-for-use (they may update bit by bit) while busy=1 and done=0.
REQ-024 start asserted in the same cycle that DONE returns to IDLE SHALL be accepted at the next edge; back-to-back operations SHALL therefore be spaced WIDTH+2 edges apart.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap while in BUSY.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, d=0, bo=0, counter=0 and borrow=0, regardless of the clock.
REQ-027 Reset during BUSY or DONE SHALL abort the operation with no done pulse.
REQ-028 The first start SHALL be accepted at the first rising edge after rst_n is released.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE, BUSY, DONE) and the default WIDTH constant.
REQ-030 The per-bit logic SHALL be a combinational sub-module, full_subtractor1 (inputs a, b, bi; outputs d, bo), instantiated once and reused every cycle.
REQ-031 All state SHALL be in this block; full_subtractor1 SHALL hold no state.

Verification
REQ-032 a=26, b=15, bi=1, start pulse -> done exactly 8 edges after the start edge; d=10, bo=0.
REQ-033 a=0, b=1, bi=0 -> d=255, bo=1; a=255, b=255, bi=1 -> d=255, bo=1.
REQ-034 a=173, b=49, bi=1 -> d=123, bo=0; then start held high continuously -> next operation begins 10 edges after the first start edge; exactly one done per operation.
REQ-035 start re-pulsed with a=0, b=0 at cycle 3 of BUSY (a=200, b=100, bi=0) -> ignored; result d=100, bo=0.
REQ-036 rst_n asserted asynchronously at cycle 4 of BUSY -> busy, done, d and bo go to 0 with no clock edge; no done pulse; a new start after release gives a correct result.
REQ-037 All 2^17 combinations of (a, b, bi) -> every d and bo matches a reference model (a - b - bi); done never asserts twice per start.
